// File: rtl/multi_circle_pkg.sv
// rtl/multi_circle_pkg.sv - shared types and constants for the multi-circle point generator
//
// Contents:
//   state_t     : generator FSM states {IDLE, SETUP, EMIT, STEP}
//   octant_t    : 3-bit index of the symmetric octant point being presented
//   NUM_OCTANTS : number of symmetric points produced per midpoint iteration
package multi_circle_pkg;

    localparam int NUM_OCTANTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EMIT,
        STEP
    } state_t;

    typedef logic [2:0] octant_t;

endpackage

// File: rtl/multi_circle_octant_mux.sv
// rtl/multi_circle_octant_mux.sv - maps a midpoint iterate to one of its eight symmetric pixels
//
// Combinational. All arithmetic is modulo 2^WIDTH, so the pixel wraps exactly
// as a full-width sum truncated to WIDTH would.
//
// Ports:
//   cx, cy     in  WIDTH  circle centre
//   x, y       in  WIDTH  current midpoint iterate (low WIDTH bits)
//   octant     in  3      which symmetric point to produce (0..7)
//   _out0      out WIDTH  pixel x
//   _out1      out WIDTH  pixel y
module multi_circle_octant_mux
    import multi_circle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cx,
    input  logic [WIDTH-1:0] cy,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  octant_t          octant,
    output logic [WIDTH-1:0] _out0,
    output logic [WIDTH-1:0] _out1
);

    always_comb begin
        _out0 = cx + x;
        _out1 = cy + y;
        case (octant)
            3'd0: begin _out0 = cx + x; _out1 = cy + y; end
            3'd1: begin _out0 = cx + y; _out1 = cy + x; end
            3'd2: begin _out0 = cx - y; _out1 = cy + x; end
            3'd3: begin _out0 = cx - x; _out1 = cy + y; end
            3'd4: begin _out0 = cx - x; _out1 = cy - y; end
            3'd5: begin _out0 = cx - y; _out1 = cy - x; end
            3'd6: begin _out0 = cx + y; _out1 = cy - x; end
            3'd7: begin _out0 = cx + x; _out1 = cy - y; end
            default: begin _out0 = cx + x; _out1 = cy + y; end
        endcase
    end

endmodule

// File: rtl/multi_circle_gen.sv
// rtl/multi_circle_gen.sv - midpoint circle point generator over a row of equal-radius circles
//
// Circle k is centred at (centre_x + k*spacing, centre_y). Each midpoint
// iteration yields eight symmetric pixels, one per accepted _valid/_ready beat.
//
// Optional feature: define MULTI_CIRCLE_GEN_COUNT_EN to add the _count output
// (points accepted in the current/last job).
//
// Ports:
//   _clock     in  1      rising-edge clock
//   _reset_n   in  1      asynchronous active-low reset
//   _start     in  1      job request, taken only when idle
//   _ready     in  1      downstream accepts the presented point
//   centre_x   in  WIDTH  x centre of circle 0 (signed)
//   centre_y   in  WIDTH  y centre of all circles (signed)
//   radius     in  WIDTH  radius of all circles (signed)
//   spacing    in  WIDTH  x step between centres (signed)
//   n_circles  in  CW     circle count, clamped to MAX_CIRCLES
//   _valid     out 1      _out0/_out1 hold a point
//   _done      out 1      no job active
//   _out0      out WIDTH  pixel x
//   _out1      out WIDTH  pixel y
//   _count     out WIDTH  accepted points (MULTI_CIRCLE_GEN_COUNT_EN only)
module multi_circle_gen
    import multi_circle_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_CIRCLES = 8
) (
    input  logic                             _clock,
    input  logic                             _reset_n,
    input  logic                             _start,
    input  logic                             _ready,
    input  logic [WIDTH-1:0]                 centre_x,
    input  logic [WIDTH-1:0]                 centre_y,
    input  logic [WIDTH-1:0]                 radius,
    input  logic [WIDTH-1:0]                 spacing,
    input  logic [$clog2(MAX_CIRCLES+1)-1:0] n_circles,
    output logic                             _valid,
    output logic                             _done,
    output logic [WIDTH-1:0]                 _out0,
    output logic [WIDTH-1:0]                 _out1
`ifdef MULTI_CIRCLE_GEN_COUNT_EN
    ,
    output logic [WIDTH-1:0]                 _count
`endif
);

    localparam int CW = $clog2(MAX_CIRCLES + 1);
    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] ONE = EW'(1);
    localparam logic [CW-1:0] MAX_N = CW'(MAX_CIRCLES);

    state_t                 state;
    logic [CW-1:0]          k;
    logic [CW-1:0]          n_lat;
    logic [WIDTH-1:0]       r_lat;
    logic [WIDTH-1:0]       cx;
    logic [WIDTH-1:0]       cy;
    logic [WIDTH-1:0]       sp_lat;
    logic signed [EW-1:0]   x;
    logic signed [EW-1:0]   y;
    logic signed [EW-1:0]   err;
    octant_t                octant;

    logic [CW-1:0]          n_clamped;
    logic signed [EW-1:0]   r_ext;
    logic signed [EW-1:0]   x_step;
    logic signed [EW-1:0]   y_step;
    logic signed [EW-1:0]   err_step;
    logic                   step_cont;
    logic [WIDTH-1:0]       feed_x;
    logic [WIDTH-1:0]       feed_y;
    octant_t                feed_oct;
    logic [WIDTH-1:0]       pix_x;
    logic [WIDTH-1:0]       pix_y;

    assign n_clamped = (n_circles > MAX_N) ? MAX_N : n_circles;
    assign r_ext     = {{2{r_lat[WIDTH-1]}}, r_lat};

    // One midpoint step; the x decrement feeds the error update of the same step.
    always_comb begin
        y_step = y + ONE;
        if (err < 0) begin
            x_step   = x;
            err_step = err + (y_step <<< 1) + ONE;
        end else begin
            x_step   = x - ONE;
            err_step = err + ((y_step - x_step) <<< 1) + ONE;
        end
    end

    assign step_cont = (x_step >= y_step);

    // The output registers load the point that will be current after this
    // edge, so the mux is fed with next-cycle iterate and octant values.
    always_comb begin
        feed_x   = x[WIDTH-1:0];
        feed_y   = y[WIDTH-1:0];
        feed_oct = octant + 3'd1;
        case (state)
            SETUP: begin
                feed_x   = r_lat;
                feed_y   = '0;
                feed_oct = '0;
            end
            STEP: begin
                feed_x   = x_step[WIDTH-1:0];
                feed_y   = y_step[WIDTH-1:0];
                feed_oct = '0;
            end
            default: begin
                feed_x   = x[WIDTH-1:0];
                feed_y   = y[WIDTH-1:0];
                feed_oct = octant + 3'd1;
            end
        endcase
    end

    multi_circle_octant_mux #(
        .WIDTH (WIDTH)
    ) u_octant_mux (
        .cx     (cx),
        .cy     (cy),
        .x      (feed_x),
        .y      (feed_y),
        .octant (feed_oct),
        ._out0  (pix_x),
        ._out1  (pix_y)
    );

    // IDLE with _done low is the operand-capture cycle of a newly accepted
    // job; it moves to SETUP on the following edge.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state  <= IDLE;
            _done  <= 1'b1;
            _valid <= 1'b0;
            _out0  <= '0;
            _out1  <= '0;
            k      <= '0;
            n_lat  <= '0;
            r_lat  <= '0;
            cx     <= '0;
            cy     <= '0;
            sp_lat <= '0;
            x      <= '0;
            y      <= '0;
            err    <= '0;
            octant <= '0;
`ifdef MULTI_CIRCLE_GEN_COUNT_EN
            _count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!_done) begin
                        state <= SETUP;
                    end else if (_start) begin
                        _done  <= 1'b0;
                        k      <= '0;
                        n_lat  <= n_clamped;
                        r_lat  <= radius;
                        cx     <= centre_x;
                        cy     <= centre_y;
                        sp_lat <= spacing;
`ifdef MULTI_CIRCLE_GEN_COUNT_EN
                        _count <= '0;
`endif
                    end
                end
                SETUP: begin
                    // k==n_lat also covers n_circles==0.
                    if ((k == n_lat) || r_lat[WIDTH-1]) begin
                        state <= IDLE;
                        _done <= 1'b1;
                    end else begin
                        x      <= r_ext;
                        y      <= '0;
                        err    <= ONE - r_ext;
                        octant <= '0;
                        _valid <= 1'b1;
                        _out0  <= pix_x;
                        _out1  <= pix_y;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (_ready) begin
`ifdef MULTI_CIRCLE_GEN_COUNT_EN
                        _count <= _count + WIDTH'(1);
`endif
                        if (octant == octant_t'(NUM_OCTANTS - 1)) begin
                            _valid <= 1'b0;
                            state  <= STEP;
                        end else begin
                            octant <= octant + 3'd1;
                            _out0  <= pix_x;
                            _out1  <= pix_y;
                        end
                    end
                end
                STEP: begin
                    x   <= x_step;
                    y   <= y_step;
                    err <= err_step;
                    if (step_cont) begin
                        octant <= '0;
                        _valid <= 1'b1;
                        _out0  <= pix_x;
                        _out1  <= pix_y;
                        state  <= EMIT;
                    end else begin
                        k     <= k + CW'(1);
                        cx    <= cx + sp_lat;
                        state <= SETUP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
